stdp_learn: RTL
===============

Name: stdp_learn

Overview:
- Spike-timing-dependent plasticity stage. Sits between the presynaptic and postsynaptic lif neurons.
- Consumes both neurons' spike outputs, tracks the time since each neuron's last spike, and pairs spikes inside a 16-cycle window.
- Applies a saturating potentiation or depression step to an 8-bit synaptic weight.
- Produces syn_current (weight gated by pre spike) as the postsynaptic neuron's input current.

Parameters:
- W_INIT, 8'd1, weight value loaded on reset.
- W_MAX, 8'd255, upper saturation bound of the weight. The lower bound is fixed at 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- pre_spike  input  1  presynaptic lif spike, one-cycle pulse.
- post_spike  input  1  postsynaptic lif spike, one-cycle pulse.
- weight  output  8  current synaptic weight (registered).
- syn_current  output  8  weight if pre_spike was sampled high at the previous edge, else 0 (registered).
- update_w_flag  output  1  one-cycle pulse in the cycle after a weight change is committed.
- ltp  output  1  direction of the last committed update: 1 = potentiation, 0 = depression. Holds until the next update.
- time_diff  output  5  dt of the last committed pairing, 1..16. Holds until the next update.

Behaviour:
- Reset values, when rst is sampled high:
  - weight=W_INIT; syn_current=0; update_w_flag=0; ltp=0; time_diff=0.
  - Both traces invalid, ages 0.
  - Pipeline stage 1 cleared; any pending update is discarded.
- Trace (one each for pre and post): age[3:0], valid.
  - Spike sampled: age<=0, valid<=1.
  - Otherwise, if valid: age<=age+1; valid<=0 when age==15.
  - Consumed by a pairing: valid<=0 (nearest-neighbour pairing; each spike pairs at most once as the partner).
- Pairing at the edge where the triggering spike is sampled; uses the pre-edge trace values. dt = partner age + 1, range 1..16.
  - post_spike only, pre valid: LTP with dt from the pre trace; the pre trace is consumed.
  - pre_spike only, post valid: LTD with dt from the post trace; the post trace is consumed.
  - Partner invalid (never spiked, consumed, or dt > 16): no update.
  - pre_spike and post_spike both high: no update; both traces restart at age 0, valid.
- Delta LUT (in package):
  - dt 1-2 -> 16
  - dt 3-4 -> 8
  - dt 5-8 -> 4
  - dt 9-16 -> 2
- Pipeline:
  - Stage 1 registers {valid, dir, delta, dt} at the pairing edge t.
  - Stage 2, at edge t+1: weight <= sat(weight ± delta); update_w_flag<=1; ltp and time_diff loaded.
  - Visible latency: the new weight is present in the cycle after edge t+1.
  - update_w_flag is low in all cycles without a commit.
- Arithmetic: computed 9-bit.
  - Potentiation: clamp to W_MAX.
  - Depression: clamp to 0 (weight < delta -> 0).
- Throughput: back-to-back pairings on consecutive edges are accepted with no stall; each commits one edge later in order.
- syn_current samples the weight register as it stands before that edge's stage-2 commit.
- rst during a pending stage 1: the update is lost and weight returns to W_INIT.

Decomposition:
- Package stdp_pkg:
  - WINDOW=16, AGE_W=4, WEIGHT_W=8.
  - LUT constants 16/8/4/2 and their dt breakpoints.
  - Function dt_to_delta(dt).
  - Direction enum {LTD=0, LTP=1}.
- Sub-module spike_trace (age counter plus valid, with a consume input), instantiated twice: pre and post.
- The top holds the pairing logic, the two pipeline stages, and the weight register.

Test Plan:
- Reset -> weight=1, syn_current=0, update_w_flag=0, time_diff=0. pre_spike at edge 5 -> syn_current=1 after edge 6, 0 after edge 7.
- pre at edge 0, post at edge 2 (dt=2) -> weight 1->17; update_w_flag high only in the cycle after edge 3; ltp=1; time_diff=2.
- After the previous scenario: post at edge 10, pre at edge 14 (dt=4) -> weight 17->9; ltp=0; time_diff=4.
- Saturation:
  - W_INIT=1: post at edge 0, pre at edge 1 -> weight 0.
  - W_INIT=250: pre at edge 0, post at edge 1 -> weight 255.
- Window and boundary:
  - pre at edge 0, post at edge 17 (dt=17) -> no flag, weight unchanged.
  - pre and post both at edge 3 -> no flag, weight unchanged.
  - pre at edge 0, post at edges 4 and 5 -> only one update (+8).
- rst asserted at edge 3 after a pairing at edge 2 -> no update_w_flag; weight=W_INIT after edge 3.

Source files
------------

// File: rtl/stdp_pkg.sv
// stdp_pkg: shared widths, pairing window and the dt-to-step lookup for the STDP stage.
package stdp_pkg;
    localparam int WINDOW = 16;
    localparam int AGE_W = 4;
    localparam int WEIGHT_W = 8;
    localparam int DT_W = 5;
    localparam logic [WEIGHT_W-1:0] D_NEAR = 8'd16;
    localparam logic [WEIGHT_W-1:0] D_SHORT = 8'd8;
    localparam logic [WEIGHT_W-1:0] D_MID = 8'd4;
    localparam logic [WEIGHT_W-1:0] D_FAR = 8'd2;
    localparam logic [DT_W-1:0] DT_NEAR = 5'd2;
    localparam logic [DT_W-1:0] DT_SHORT = 5'd4;
    localparam logic [DT_W-1:0] DT_MID = 5'd8;
    typedef enum logic {LTD = 1'b0, LTP = 1'b1} dir_e;
    function automatic logic [WEIGHT_W-1:0] dt_to_delta(input logic [DT_W-1:0] dt);
        return dt <= DT_NEAR ? D_NEAR : dt <= DT_SHORT ? D_SHORT : dt <= DT_MID ? D_MID : D_FAR;
    endfunction
endpackage

// File: rtl/spike_trace.sv
// spike_trace: age since the last spike, valid for WINDOW cycles unless consumed by a pairing.
module spike_trace
    import stdp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_i,
    input  logic             consume_i,
    output logic [AGE_W-1:0] age_o,
    output logic             valid_o
);
    logic [AGE_W-1:0] age_q, age_d;
    logic valid_q, valid_d;
    always_comb begin
        age_d = age_q;
        valid_d = valid_q;
        if (spike_i) begin
            age_d = '0;
            valid_d = 1'b1;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            age_d = age_q + 1'b1;
            valid_d = age_q != AGE_W'(WINDOW - 1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= '0;
            valid_q <= 1'b0;
        end else begin
            age_q <= age_d;
            valid_q <= valid_d;
        end
    end
    assign age_o = age_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/stdp_learn.sv
// stdp_learn: nearest-neighbour spike pairing feeding a two-stage saturating weight update,
// plus the pre-gated synaptic current for the postsynaptic neuron.
module stdp_learn
    import stdp_pkg::*;
#(
    parameter logic [WEIGHT_W-1:0] W_INIT = 8'd1,
    parameter logic [WEIGHT_W-1:0] W_MAX = 8'd255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pre_spike,
    input  logic                post_spike,
    output logic [WEIGHT_W-1:0] weight,
    output logic [WEIGHT_W-1:0] syn_current,
    output logic                update_w_flag,
    output logic                ltp,
    output logic [DT_W-1:0]     time_diff
);
    logic [AGE_W-1:0] pre_age, post_age;
    logic pre_valid, post_valid, ltp_pair, ltd_pair;
    logic [DT_W-1:0] pair_dt;
    logic s1_valid_q, pre_q, flag_q;
    dir_e s1_dir_q, ltp_q;
    logic [WEIGHT_W-1:0] s1_delta_q, weight_q, weight_d, syn_q, w_up, w_dn;
    logic [DT_W-1:0] s1_dt_q, time_diff_q;
    logic [WEIGHT_W:0] sum;
    assign ltp_pair = post_spike & ~pre_spike & pre_valid;
    assign ltd_pair = pre_spike & ~post_spike & post_valid;
    assign pair_dt = {1'b0, ltp_pair ? pre_age : post_age} + 5'd1;
    spike_trace u_pre (
        .clk(clk), .rst(rst), .spike_i(pre_spike), .consume_i(ltp_pair),
        .age_o(pre_age), .valid_o(pre_valid)
    );
    spike_trace u_post (
        .clk(clk), .rst(rst), .spike_i(post_spike), .consume_i(ltd_pair),
        .age_o(post_age), .valid_o(post_valid)
    );
    // 9-bit sum so potentiation overflow is caught before clamping to W_MAX
    always_comb begin
        sum = {1'b0, weight_q} + {1'b0, s1_delta_q};
        w_up = sum > {1'b0, W_MAX} ? W_MAX : sum[WEIGHT_W-1:0];
        w_dn = weight_q < s1_delta_q ? '0 : weight_q - s1_delta_q;
        weight_d = !s1_valid_q ? weight_q : s1_dir_q == LTP ? w_up : w_dn;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_dir_q <= LTD;
            s1_delta_q <= '0;
            s1_dt_q <= '0;
            weight_q <= W_INIT;
            flag_q <= 1'b0;
            ltp_q <= LTD;
            time_diff_q <= '0;
            pre_q <= 1'b0;
            syn_q <= '0;
        end else begin
            s1_valid_q <= ltp_pair | ltd_pair;
            s1_dir_q <= ltp_pair ? LTP : LTD;
            s1_delta_q <= dt_to_delta(pair_dt);
            s1_dt_q <= pair_dt;
            weight_q <= weight_d;
            flag_q <= s1_valid_q;
            ltp_q <= s1_valid_q ? s1_dir_q : ltp_q;
            time_diff_q <= s1_valid_q ? s1_dt_q : time_diff_q;
            pre_q <= pre_spike;
            syn_q <= pre_q ? weight_q : '0;
        end
    end
    assign weight = weight_q;
    assign syn_current = syn_q;
    assign update_w_flag = flag_q;
    assign ltp = ltp_q == LTP;
    assign time_diff = time_diff_q;
endmodule
